// File: rtl/digest_out_serializer_if.sv
// rtl/digest_out_serializer_if.sv - digest hand-over and byte stream signal bundle
interface digest_out_serializer_if #(
   parameter int DIGEST_W = 256,
   parameter int LEN_W    = 6
);
   logic                digest_v_i;
   logic [DIGEST_W-1:0] digest_i;
   logic [LEN_W-1:0]    digest_len_i;
   logic                ready_o;
   logic                hold_i;
   logic [7:0]          data_o;
   logic                data_o_v;
   logic                last_o;
   logic                err_o;

   modport master (
      output digest_v_i, digest_i, digest_len_i, hold_i,
      input  ready_o, data_o, data_o_v, last_o, err_o
   );

   modport slave (
      input  digest_v_i, digest_i, digest_len_i, hold_i,
      output ready_o, data_o, data_o_v, last_o, err_o
   );
endinterface

// File: rtl/digest_out_serializer.sv
// rtl/digest_out_serializer.sv - streams a finished digest out one byte per cycle
module digest_out_serializer #(
   parameter int DIGEST_W = 256,
   parameter int LEN_W    = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   digest_out_serializer_if.slave  bus
);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DIGEST_W / 8);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t              state;
   logic [DIGEST_W-1:0] act_sr;
   logic [LEN_W-1:0]    act_len;
   logic [LEN_W-1:0]    cnt;
   logic [DIGEST_W-1:0] pend_sr;
   logic [LEN_W-1:0]    pend_len;
   logic                pend_v;
   logic                err_q;

   logic consume, final_c, accept, drop;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      if (l == '0 || l > MAX_LEN) return MAX_LEN;
      return l;
   endfunction

   assign consume = (state == STREAM) && !bus.hold_i;
   assign final_c = consume && (cnt == act_len - LEN_W'(1));
   assign accept  = bus.digest_v_i && !pend_v;
   assign drop    = bus.digest_v_i && pend_v;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         act_sr   <= '0;
         act_len  <= '0;
         cnt      <= '0;
         pend_sr  <= '0;
         pend_len <= '0;
         pend_v   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (drop) err_q <= 1'b1;

         case (state)
            IDLE: begin
               if (accept) begin
                  act_sr  <= bus.digest_i;
                  act_len <= clamp_len(bus.digest_len_i);
                  cnt     <= '0;
                  state   <= STREAM;
               end
            end
            STREAM: begin
               if (final_c) begin
                  // Back-to-back hand-over keeps the stream free of bubbles.
                  if (pend_v) begin
                     act_sr  <= pend_sr;
                     act_len <= pend_len;
                     cnt     <= '0;
                     pend_v  <= 1'b0;
                  end else if (accept) begin
                     act_sr  <= bus.digest_i;
                     act_len <= clamp_len(bus.digest_len_i);
                     cnt     <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (consume) begin
                  act_sr <= act_sr >> 8;
                  cnt    <= cnt + LEN_W'(1);
               end

               if (accept && !final_c) begin
                  pend_sr  <= bus.digest_i;
                  pend_len <= clamp_len(bus.digest_len_i);
                  pend_v   <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ready_o  = ~pend_v;
   assign bus.data_o_v = (state == STREAM);
   assign bus.data_o   = act_sr[7:0];
   assign bus.last_o   = (state == STREAM) && (cnt == act_len - LEN_W'(1));
   assign bus.err_o    = err_q;
endmodule

// File: tb/tb_digest_out_serializer.sv
// tb/tb_digest_out_serializer.sv - directed and random checks against a byte-queue model
module tb_digest_out_serializer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   digest_out_serializer_if #(.DIGEST_W(256), .LEN_W(6)) bus ();

   digest_out_serializer #(.DIGEST_W(256), .LEN_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: bytes still to be shown for the active digest, plus an optional waiting digest.
   logic [7:0] act_q[$];
   logic [7:0] pend_q[$];
   bit         m_pend_v = 0;
   bit         m_err = 0;
   bit         chk_zero = 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("data_o_v", 32'(bus.data_o_v), 32'(act_q.size() != 0));
      chk("last_o", 32'(bus.last_o), 32'(act_q.size() == 1));
      chk("ready_o", 32'(bus.ready_o), 32'(!m_pend_v));
      chk("err_o", 32'(bus.err_o), 32'(m_err));
      if (act_q.size() != 0) chk("data_o", 32'(bus.data_o), 32'(act_q[0]));
      else if (chk_zero) chk("data_o_rst", 32'(bus.data_o), 32'd0);
   endtask

   task automatic model_edge();
      logic [7:0] nb[$];
      int         n;
      bit         acc, drp;
      if (!rst_n) begin
         act_q.delete();
         pend_q.delete();
         m_pend_v = 0;
         m_err = 0;
         chk_zero = 1;
         return;
      end
      chk_zero = 0;
      acc = bus.digest_v_i && !m_pend_v;
      drp = bus.digest_v_i && m_pend_v;
      if (act_q.size() != 0 && !bus.hold_i) void'(act_q.pop_front());
      if (act_q.size() == 0 && m_pend_v) begin
         act_q = pend_q;
         m_pend_v = 0;
      end
      if (drp) m_err = 1;
      if (acc) begin
         n = int'(bus.digest_len_i);
         if (n == 0 || n > 32) n = 32;
         for (int k = 0; k < n; k++) nb.push_back(bus.digest_i[8*k +: 8]);
         if (act_q.size() == 0) act_q = nb;
         else begin
            pend_q = nb;
            m_pend_v = 1;
         end
      end
   endtask

   task automatic step();
      check_outputs();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse(input logic [255:0] d, input logic [5:0] l);
      bus.digest_v_i   = 1'b1;
      bus.digest_i     = d;
      bus.digest_len_i = l;
      step();
      bus.digest_v_i   = 1'b0;
   endtask

   function automatic logic [255:0] seq_digest(input logic [7:0] base);
      logic [255:0] d;
      for (int k = 0; k < 32; k++) d[8*k +: 8] = base + 8'(k);
      return d;
   endfunction

   function automatic logic [255:0] rnd_digest();
      logic [255:0] d;
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
      return d;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      bus.digest_v_i   = 1'b0;
      bus.digest_i     = '0;
      bus.digest_len_i = '0;
      bus.hold_i       = 1'b0;
      rst_n            = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      do_reset();

      // Full 32-byte digest, no stalls
      pulse(seq_digest(8'h00), 6'd32);
      run(34);

      // Four bytes with a 3-cycle stall on the second byte
      pulse({224'h0, 32'hDDCCBBAA}, 6'd4);
      step();
      bus.hold_i = 1'b1;
      run(3);
      bus.hold_i = 1'b0;
      run(5);

      // Pending digest handed over without a gap
      pulse(seq_digest(8'h00), 6'd32);
      run(9);
      pulse({240'h0, 16'h2211}, 6'd2);
      run(40);

      // Third pulse while pending is full is dropped
      pulse(seq_digest(8'h40), 6'd32);
      run(5);
      pulse({240'h0, 16'h2211}, 6'd2);
      run(2);
      pulse(rnd_digest(), 6'd7);
      run(40);

      // Length clamp corners
      pulse(seq_digest(8'h80), 6'd0);
      run(34);
      pulse(seq_digest(8'hA0), 6'd40);
      run(34);
      pulse(seq_digest(8'h5A), 6'd1);
      run(3);

      // Reset mid-stream with pending full and err set
      do_reset();
      pulse(seq_digest(8'h10), 6'd32);
      run(3);
      pulse(rnd_digest(), 6'd5);
      pulse(rnd_digest(), 6'd3);
      run(5);
      do_reset();
      run(40);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         bus.digest_v_i   = ($urandom_range(0, 5) == 0);
         bus.digest_i     = rnd_digest();
         bus.digest_len_i = 6'($urandom_range(0, 45));
         bus.hold_i       = ($urandom_range(0, 3) == 0);
         rst_n            = ($urandom_range(0, 499) != 0);
         step();
      end
      bus.digest_v_i = 1'b0;
      bus.hold_i     = 1'b0;
      rst_n          = 1'b1;
      run(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
